// File: rtl/phase_pkg.sv
// Shared definitions for the stochastic-bitstream phase shifter.
// rotr() is the single reference for circular right rotation; the RTL
// barrel levels and the bench model both call it.
package phase_pkg;

    // Width of the phase index k (rotate amount 0..3).
    localparam int PHASE_W = 2;

    // Widest stream word rotr() can handle; narrower words are zero-extended
    // into this container and rotated within their own width.
    localparam int ROT_MAX_W = 256;
    localparam int ROT_IDX_W = $clog2(ROT_MAX_W);

    typedef logic [ROT_MAX_W-1:0] rot_word_t;

    // Rotate the low w bits of v right by sh positions: r[i] = v[(i+sh) mod w].
    // Bits at and above w come back as zero. w defaults to the 64-bit stream.
    // With constant sh and w the loop folds to pure wiring.
    function automatic rot_word_t rotr(input rot_word_t v, input int unsigned sh,
                                       input int unsigned w = 64);
        rot_word_t             r;
        logic [ROT_IDX_W-1:0]  src;
        r = '0;
        for (int unsigned i = 0; i < ROT_MAX_W; i++) begin
            if (i < w) begin
                src  = ROT_IDX_W'((i + sh) % w);
                r[i] = v[src];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/phase_rotr.sv
// Combinational two-level barrel rotator: level g rotates right by 2**g
// when k[g] is set, so the two levels together rotate by k (0..3).
module phase_rotr
    import phase_pkg::*;
#(
    parameter int BITSTREAM = 64
) (
    input  logic [PHASE_W-1:0]   k,
    input  logic [BITSTREAM-1:0] in_bits,
    output logic [BITSTREAM-1:0] out_bits
);

    if (BITSTREAM > ROT_MAX_W) begin : g_bad_width
        $error("phase_rotr: BITSTREAM (%0d) exceeds rotr container (%0d)", BITSTREAM, ROT_MAX_W);
    end

    // lvl[0] is the raw word, lvl[g+1] is the word after barrel level g.
    logic [BITSTREAM-1:0] lvl [PHASE_W+1];

    assign lvl[0] = in_bits;

    // One conditional fixed-distance rotate per bit of k.
    for (genvar g = 0; g < PHASE_W; g++) begin : g_level
        localparam int unsigned SH = 1 << g;
        assign lvl[g+1] = k[g] ? BITSTREAM'(rotr(rot_word_t'(lvl[g]), SH, BITSTREAM))
                               : lvl[g];
    end

    assign out_bits = lvl[PHASE_W];

endmodule

// File: rtl/phase_2b.sv
// Registered phase-shift stage for unipolar stochastic bitstreams.
// Each accepted word is rotated right by k and presented one cycle later;
// rotation preserves popcount, so the stream value is unchanged.
module phase_2b
    import phase_pkg::*;
#(
    parameter int BITSTREAM = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [PHASE_W-1:0]   k,
    input  logic [BITSTREAM-1:0] in_bits,
    output logic                 out_valid,
    output logic [BITSTREAM-1:0] out_bits
);

    if (BITSTREAM < 4) begin : g_bad_width
        $error("phase_2b: BITSTREAM (%0d) must be at least 4", BITSTREAM);
    end

    logic [BITSTREAM-1:0] rot_bits;

    phase_rotr #(
        .BITSTREAM (BITSTREAM)
    ) u_rotr (
        .k        (k),
        .in_bits  (in_bits),
        .out_bits (rot_bits)
    );

    // Valid follows the accept strobe by exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_valid <= 1'b0;
        else     out_valid <= in_valid;
    end

    // Load only on accept so idle-cycle (possibly X) inputs never reach the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           out_bits <= '0;
        else if (in_valid) out_bits <= rot_bits;
    end

endmodule

// File: tb/tb_phase_2b.sv
// Bench for phase_2b: three instances (64, 4 and 128 bits) share one
// stimulus stream. Expected results are queued at drive time and compared
// when the matching output cycle arrives.
module tb_phase_2b;
    import phase_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [1:0]   k;
    logic [127:0] din;

    logic         ov64, ov4, ov128;
    logic [63:0]  ob64;
    logic [3:0]   ob4;
    logic [127:0] ob128;

    phase_2b #(.BITSTREAM(64)) d64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .k(k), .in_bits(din[63:0]),
        .out_valid(ov64), .out_bits(ob64));
    phase_2b #(.BITSTREAM(4)) d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .k(k), .in_bits(din[3:0]),
        .out_valid(ov4), .out_bits(ob4));
    phase_2b #(.BITSTREAM(128)) d128 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .k(k), .in_bits(din),
        .out_valid(ov128), .out_bits(ob128));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           due;
        logic         vld;
        logic [63:0]  b64;
        logic [3:0]   b4;
        logic [127:0] b128;
        int           pc64;
        int           pc128;
    } exp_t;

    typedef struct {
        logic [1:0]   k;
        logic [127:0] din;
        logic [63:0]  e64;
        logic [3:0]   e4;
        logic [127:0] e128;
    } vec_t;

    exp_t         sb[$];
    logic [63:0]  last64;
    logic [3:0]   last4;
    logic [127:0] last128;
    int           nchk = 0;
    int           nerr = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Drive one cycle (called at posedge+1) and queue what it should produce.
    task automatic drive(input logic v, input logic [1:0] kk, input logic [127:0] d,
                         input logic [63:0] e64, input logic [3:0] e4, input logic [127:0] e128);
        exp_t e;
        in_valid = v;
        k        = kk;
        din      = d;
        if (v) begin
            last64  = e64;
            last4   = e4;
            last128 = e128;
        end
        e.due   = cyc + 1;
        e.vld   = v;
        e.b64   = last64;
        e.b4    = last4;
        e.b128  = last128;
        e.pc64  = $countones(d[63:0]);
        e.pc128 = $countones(d);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_model(input logic [1:0] kk, input logic [127:0] d);
        drive(1'b1, kk, d,
              64'(rotr(rot_word_t'(d[63:0]), kk, 64)),
              4'(rotr(rot_word_t'(d[3:0]), kk, 4)),
              128'(rotr(rot_word_t'(d), kk, 128)));
    endtask

    task automatic idle();
        drive(1'b0, 2'bxx, {128{1'bx}}, '0, '0, '0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard: pop the entry due this cycle and compare all three instances.
    always @(negedge clk) begin : mon
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("valid64",  128'(ov64),  128'(e.vld));
            chk("valid4",   128'(ov4),   128'(e.vld));
            chk("valid128", 128'(ov128), 128'(e.vld));
            chk("bits64",   128'(ob64),  128'(e.b64));
            chk("bits4",    128'(ob4),   128'(e.b4));
            chk("bits128",  ob128,       e.b128);
            if (e.vld) begin
                chk("popcount64",  128'($countones(ob64)),  128'(e.pc64));
                chk("popcount128", 128'($countones(ob128)), 128'(e.pc128));
            end
        end else if (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            chk("sb_missed", 128'(cyc), 128'(e.due));
        end
    end

    vec_t vecs[$];

    initial begin
        // Directed vectors with hand-derived results for all three widths.
        vecs.push_back('{2'd1, 128'h1, 64'h8000_0000_0000_0000, 4'b1000,
                         128'h8000_0000_0000_0000_0000_0000_0000_0000});
        vecs.push_back('{2'd3, 128'h1, 64'h2000_0000_0000_0000, 4'b0010,
                         128'h2000_0000_0000_0000_0000_0000_0000_0000});
        vecs.push_back('{2'd0, 128'h1, 64'h0000_0000_0000_0001, 4'b0001, 128'h1});
        vecs.push_back('{2'd2, 128'h0123_4567_89AB_CDEF, 64'hC048_D159_E26A_F37B, 4'hF,
                         128'hC000_0000_0000_0000_0048_D159_E26A_F37B});
        vecs.push_back('{2'd3, 128'h0123_4567_89AB_CDEF, 64'hE024_68AC_F135_79BD, 4'hF,
                         128'hE000_0000_0000_0000_0024_68AC_F135_79BD});
        vecs.push_back('{2'd2, 128'h3, 64'hC000_0000_0000_0000, 4'hC,
                         128'hC000_0000_0000_0000_0000_0000_0000_0000});
        vecs.push_back('{2'd1, 128'h8, 64'h4, 4'h4, 128'h4});

        rst      = 1'b1;
        in_valid = 1'b0;
        k        = '0;
        din      = '0;
        last64   = '0;
        last4    = '0;
        last128  = '0;

        // Reset state.
        #12;
        chk("rst_valid64", 128'(ov64), 128'(0));
        chk("rst_bits64",  128'(ob64), 128'(0));
        chk("rst_bits128", ob128,      128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed rotations, back to back.
        foreach (vecs[i]) drive(1'b1, vecs[i].k, vecs[i].din, vecs[i].e64, vecs[i].e4, vecs[i].e128);
        idle();

        // Gaps with X inputs on idle cycles: output holds, valid goes 1,0,0,1.
        drive_model(2'd1, rnd128());
        idle();
        idle();
        drive_model(2'd2, rnd128());
        idle();

        // Continuous streaming with k = cycle mod 4.
        for (int i = 0; i < 101; i++) drive_model(2'(i % 4), rnd128());
        idle();

        // Mid-stream asynchronous reset.
        drive_model(2'd3, rnd128());
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        k        = 2'd1;
        din      = rnd128();
        rst      = 1'b1;
        #1;
        chk("async_rst_valid64", 128'(ov64),  128'(0));
        chk("async_rst_bits64",  128'(ob64),  128'(0));
        chk("async_rst_bits4",   128'(ob4),   128'(0));
        chk("async_rst_bits128", ob128,       128'(0));
        // Accept attempt while reset is held is dropped.
        @(posedge clk);
        #1;
        chk("rst_wins_valid", 128'(ov64), 128'(0));
        chk("rst_wins_bits",  128'(ob64), 128'(0));
        rst      = 1'b0;
        in_valid = 1'b0;
        last64   = '0;
        last4    = '0;
        last128  = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("post_rst_valid", 128'(ov64), 128'(0));
            chk("post_rst_bits",  128'(ob64), 128'(0));
        end

        // First accept after release.
        drive_model(2'd2, 128'h0123_4567_89AB_CDEF);
        idle();

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #1;
        chk("sb_drain", 128'(sb.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/phase_2b.md
# phase_2b

Registered phase-shift stage for unipolar stochastic bitstreams. Each accepted word of `BITSTREAM` bits is rotated right by a 2-bit phase index `k` (0..3 positions), which de-correlates streams before downstream stochastic arithmetic. It sits on the bitstream datapath after stream generation and before the stochastic combinational operators. One output word is produced per accepted input word, with fixed one-cycle latency.

## Interface
Parameters:
- `BITSTREAM`, default 64, is the stream word width in bits. It must be at least 4. Elaboration fails via `$error` otherwise.

Ports:
- `clk`  in  1  is the single clock. All state is on the rising edge.
- `rst`  in  1  is the reset: asynchronous and active-high.
- `in_valid`  in  1  qualifies `k` and `in_bits` for the current cycle.
- `k`  in  2  is the phase index, i.e. the rotate-right amount in bit positions (0..3).
- `in_bits`  in  `BITSTREAM`  is the input bitstream word.
- `out_valid`  out  1  is high for exactly one cycle per accepted input.
- `out_bits`  out  `BITSTREAM`  is the rotated bitstream word.

## Operation
- Rotation is circular right by `k`:
  - `out_bits[i] = in_bits[(i + k) mod BITSTREAM]` for every i in 0..BITSTREAM-1.
  - `k=0` passes the word through unchanged.
  - Bits leaving the LSB end re-enter at the MSB end. No bit is lost, so popcount (the stream value) is preserved exactly.
- `k` is taken as a 2-bit unsigned value. No modulo is needed because `k < 4 <= BITSTREAM`.
- Rotation is a two-level barrel structure:
  - level 0 rotates by 1 when `k[0]` is set;
  - level 1 rotates by 2 when `k[1]` is set.
  - The result is registered.
- The cycle where `in_valid=1` is the accept cycle. `k` and `in_bits` are sampled only at that edge.
- When `in_valid=0`:
  - `out_bits` holds its last value;
  - `out_valid` deasserts on the next edge.
- There is no backpressure. The block accepts every cycle and has no ready signal.
- X handling: `k` and `in_bits` are don't-care when `in_valid=0`. They must not propagate into `out_bits`.

## Timing
- Latency is 1 cycle. An input accepted at rising edge N appears on `out_bits`/`out_valid` after edge N. Throughput is one word per cycle.
- Back-to-back accepts on consecutive cycles produce consecutive outputs in order, each with its own `k`.
- Reset, whenever `rst` is asserted (including mid-stream):
  - `out_bits` = 0 and `out_valid` = 0 immediately, independent of `clk`;
  - any in-flight word is discarded.
- Reset release: the first input is accepted on the first rising edge where `rst=0` and `in_valid=1`.
- Simultaneous `rst` and `in_valid`: reset wins and the input is dropped.
- No combinational path from inputs to outputs.

## Structure
- Package `phase_pkg` holds:
  - `localparam int PHASE_W = 2`;
  - `function automatic rotr(input logic [BITSTREAM-1:0] v, input int unsigned sh)`, used by both the RTL rotator and the bench model. It is parameterized via a typed width argument or a package parameter default of 64.
- One natural sub-module, `phase_rotr`:
  - purely combinational, parameterized by `BITSTREAM`;
  - inputs `k` and `in_bits`, output the rotated word;
  - implements the two generate-based barrel levels.
- The top `phase_2b` contains only the input-qualified output register and the valid register.

## Test plan
With `BITSTREAM=64`:
1. Reset: assert `rst` mid-stream → `out_bits`=0 and `out_valid`=0 immediately, before any clock edge. After release with `in_valid=0`, both stay 0.
2. Single-bit rotations:
   - `in_bits`=64'h0000_0000_0000_0001, k=1 → `out_bits`=64'h8000_0000_0000_0000;
   - same input, k=3 → 64'h2000_0000_0000_0000;
   - same input, k=0 → 64'h0000_0000_0000_0001.
3. Pattern word `in_bits`=64'h0123_4567_89AB_CDEF:
   - k=2 → 64'hC048_D159_E26A_F37B;
   - k=3 → 64'hE024_68AC_F135_79BD.
   - Each result arrives one cycle after accept with `out_valid`=1.
4. Back-to-back streaming: 101 consecutive cycles with `in_valid`=1, random 64-bit `in_bits`, and k = cycle mod 4 → each output matches the `rotr` model one cycle later, and popcount(`out_bits`) = popcount(`in_bits`).
5. Gaps: `in_valid` toggles 1,0,0,1 with X on inputs during the idle cycles → `out_bits` holds its last value, `out_valid` pattern is 1,0,0,1 delayed by one cycle, and no X ever appears on the outputs.
6. Width sweep: rerun scenarios 2 and 4 with `BITSTREAM`=4 and 128. For example, at width 4, `in_bits`=4'b0001 with k=1 → `out_bits`=4'b1000.
